// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the shared RAM port arbiter.
// The requesters/RAM use master; the arbiter uses slave.
interface mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  localparam int N   = 2 * CPUS;
  localparam int IDW = $clog2(N);

  logic [N-1:0]             req_ren;
  logic [N-1:0]             req_wen;
  logic [N-1:0]             req_burst;
  logic [N-1:0][WORD_W-1:0] req_addr;
  logic [N-1:0][WORD_W-1:0] req_store;
  logic [N-1:0]             req_wait;
  logic [WORD_W-1:0]        req_load;

  logic                     ramREN;
  logic                     ramWEN;
  logic [WORD_W-1:0]        ramaddr;
  logic [WORD_W-1:0]        ramstore;
  logic [WORD_W-1:0]        ramload;
  logic [1:0]               ramstate;

  logic [IDW-1:0]           grant_id;
  logic                     busy;
  logic                     err;

  modport master (
    output req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy, err
  );

  modport slave (
    input  req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port among CPUS data caches and CPUS instruction caches.
// Data beats instruction; round-robin inside each class; 1- or 2-word transfers.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);
  localparam int N   = 2 * CPUS;
  localparam int IDW = $clog2(N);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER0 = 2'd1, XFER1 = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic [IDW-1:0] rr_d_reg, rr_d_next;
  logic [IDW-1:0] rr_i_reg, rr_i_next;
  logic           burst_reg, burst_next;

  logic [N-1:0]   pending;
  logic           any_d, any_i;
  logic [IDW-1:0] sel_d, sel_i;
  logic           word_done;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign pending[gi]      = bus.req_ren[gi] | bus.req_wen[gi];
      assign bus.req_wait[gi] = ~(word_done && (grant_reg == IDW'(gi)));
    end
  endgenerate

  // Scan each class from the highest offset down so the nearest pending
  // requester at or after the pointer is the last one written.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    idx   = 0;
    idx_v = '0;
    any_d = 1'b0;
    sel_d = rr_d_reg;
    any_i = 1'b0;
    sel_i = rr_i_reg;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = int'(rr_d_reg) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      idx_v = IDW'(idx);
      if (pending[idx_v]) begin
        any_d = 1'b1;
        sel_d = idx_v;
      end
    end
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = int'(rr_i_reg) - CPUS + k;
      if (idx >= CPUS) idx = idx - CPUS;
      idx_v = IDW'(idx + CPUS);
      if (pending[idx_v]) begin
        any_i = 1'b1;
        sel_i = idx_v;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    burst_next   = burst_reg;
    rr_d_next    = rr_d_reg;
    rr_i_next    = rr_i_reg;
    word_done    = 1'b0;
    bus.err      = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_reg)
      IDLE: begin
        if (any_d) begin
          grant_next = sel_d;
          burst_next = bus.req_burst[sel_d];
          rr_d_next  = (sel_d == IDW'(CPUS - 1)) ? '0 : sel_d + 1'b1;
          state_next = XFER0;
        end else if (any_i) begin
          grant_next = sel_i;
          burst_next = bus.req_burst[sel_i];
          rr_i_next  = (sel_i == IDW'(N - 1)) ? IDW'(CPUS) : sel_i + 1'b1;
          state_next = XFER0;
        end
      end
      XFER0, XFER1: begin
        // A requester that drops both enables abandons the transfer silently.
        if (!pending[grant_reg]) begin
          state_next = IDLE;
        end else begin
          bus.ramWEN   = bus.req_wen[grant_reg];
          bus.ramREN   = bus.req_ren[grant_reg] & ~bus.req_wen[grant_reg];
          bus.ramaddr  = bus.req_addr[grant_reg] + ((state_reg == XFER1) ? WORD_W'(4) : '0);
          bus.ramstore = bus.req_store[grant_reg];
          if (bus.ramstate == RAM_ACCESS) begin
            word_done  = 1'b1;
            state_next = (state_reg == XFER0 && burst_reg) ? XFER1 : IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            word_done  = 1'b1;
            bus.err    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      burst_reg <= 1'b0;
      rr_d_reg  <= '0;
      rr_i_reg  <= IDW'(CPUS);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      burst_reg <= burst_next;
      rr_d_reg  <= rr_d_next;
      rr_i_reg  <= rr_i_next;
    end
  end

  assign bus.req_load = word_done ? bus.ramload : '0;
  assign bus.grant_id = grant_reg;
  assign bus.busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of the arbiter's handshake corners, then a randomized run
// scored against a word-level memory model through per-requester queues.
module tb_mem_arbiter;
  localparam int CPUS = 2;
  localparam int N    = 2 * CPUS;
  localparam int W    = 32;
  localparam int TXNS = 150;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.CPUS(CPUS), .WORD_W(W)) bus ();
  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
  } word_t;

  logic [31:0] ram_mem [0:255];
  logic [31:0] exp_mem [0:255];
  word_t       exp_q [N][$];
  word_t       e;
  bit          rand_phase = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always_comb bus.ramload = ram_mem[bus.ramaddr[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wait"},  32'(bus.req_wait), 32'((1 << N) - 1));
    chk({tag, "_load"},  bus.req_load, 0);
    chk({tag, "_addr"},  bus.ramaddr, 0);
    chk({tag, "_store"}, bus.ramstore, 0);
    chk({tag, "_ren"},   32'(bus.ramREN), 0);
    chk({tag, "_wen"},   32'(bus.ramWEN), 0);
    chk({tag, "_grant"}, 32'(bus.grant_id), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_err"},   32'(bus.err), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_act(input bit a [N]);
    for (int r = 0; r < N; r++) if (a[r]) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard monitor: every wait-low cycle must match the oldest word
  // that requester is owed.
  always @(negedge clk) begin
    if (rand_phase) begin
      for (int r = 0; r < N; r++) begin
        if (!bus.req_wait[r]) begin
          if (exp_q[r].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_wait: requester %0d got a word, expected none", r);
          end else begin
            e = exp_q[r].pop_front();
            chk($sformatf("rq%0d_grant", r), 32'(bus.grant_id), 32'(r));
            chk($sformatf("rq%0d_addr", r), bus.ramaddr, e.addr);
            chk($sformatf("rq%0d_wen", r), 32'(bus.ramWEN), 32'(e.wr));
            chk($sformatf("rq%0d_ren", r), 32'(bus.ramREN), 32'(!e.wr));
            if (e.wr) chk($sformatf("rq%0d_store", r), bus.ramstore, e.data);
            else      chk($sformatf("rq%0d_load", r), bus.req_load, e.data);
            $display("txn req=%0d %s addr=0x%08h data=0x%08h", r, e.wr ? "WR" : "RD", e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    int          nlow;
    int          got[$];
    int          exp_d[4];
    int          exp_i[3];
    bit          act[N];
    int          left[N];
    logic [31:0] w2data[N];
    logic [N-1:0] done;
    int          issued;

    exp_d = '{0, 1, 0, 1};
    exp_i = '{2, 3, 2};
    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_burst = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramstate  = S_FREE;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      exp_mem[i] = ram_mem[i];
    end
    ram_mem[64] = 32'hDEADBEEF;
    exp_mem[64] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    nrst = 1'b1;

    // Single read on d0 with immediate ACCESS.
    step();
    bus.ramstate = S_ACC;
    bus.req_addr[0] = 32'h100;
    bus.req_ren[0] = 1'b1;
    @(negedge clk);
    chk("rd_idle_busy", 32'(bus.busy), 0);
    chk("rd_idle_ren", 32'(bus.ramREN), 0);
    step();
    @(negedge clk);
    chk("rd_ren", 32'(bus.ramREN), 1);
    chk("rd_addr", bus.ramaddr, 32'h100);
    chk("rd_wait", 32'(bus.req_wait), 32'b1110);
    chk("rd_load", bus.req_load, 32'hDEADBEEF);
    step();
    bus.req_ren[0] = 1'b0;
    @(negedge clk);
    chk("rd_after_busy", 32'(bus.busy), 0);

    // Burst write on d1, two BUSY cycles before each ACCESS.
    step();
    bus.req_addr[1] = 32'h200;
    bus.req_wen[1] = 1'b1;
    bus.req_burst[1] = 1'b1;
    bus.req_store[1] = 32'hA5A50001;
    bus.ramstate = S_BUSY;
    nlow = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.ramstate = (c == 3 || c == 6) ? S_ACC : S_BUSY;
      if (c == 4) bus.req_store[1] = 32'h5A5A0002;
      @(negedge clk);
      chk($sformatf("bw_wen_c%0d", c), 32'(bus.ramWEN), 1);
      chk($sformatf("bw_addr_c%0d", c), bus.ramaddr, (c <= 3) ? 32'h200 : 32'h204);
      if (!bus.req_wait[1]) nlow++;
    end
    chk("bw_store2", bus.ramstore, 32'h5A5A0002);
    chk("bw_wait_lows", 32'(nlow), 2);
    step();
    bus.req_wen[1] = 1'b0;
    bus.req_burst[1] = 1'b0;
    @(negedge clk);
    chk("bw_after_busy", 32'(bus.busy), 0);

    // Read and write together on d0 is a write.
    step();
    bus.req_addr[0] = 32'h40;
    bus.req_ren[0] = 1'b1;
    bus.req_wen[0] = 1'b1;
    bus.ramstate = S_ACC;
    step();
    @(negedge clk);
    chk("rw_wen", 32'(bus.ramWEN), 1);
    chk("rw_ren", 32'(bus.ramREN), 0);
    chk("rw_wait", 32'(bus.req_wait), 32'b1110);
    step();
    bus.req_ren[0] = 1'b0;
    bus.req_wen[0] = 1'b0;

    // ERROR on the first word of a burst ends the transfer.
    step();
    bus.req_addr[0] = 32'h80;
    bus.req_ren[0] = 1'b1;
    bus.req_burst[0] = 1'b1;
    bus.ramstate = S_ERR;
    step();
    @(negedge clk);
    chk("er_err", 32'(bus.err), 1);
    chk("er_wait", 32'(bus.req_wait), 32'b1110);
    step();
    bus.ramstate = S_ACC;
    @(negedge clk);
    chk("er_idle_busy", 32'(bus.busy), 0);
    chk("er_idle_err", 32'(bus.err), 0);
    chk("er_idle_wait", 32'(bus.req_wait), 32'b1111);
    bus.req_ren[0] = 1'b0;
    bus.req_burst[0] = 1'b0;

    // Withdrawal during XFER0 under BUSY.
    step();
    bus.req_addr[0] = 32'hC0;
    bus.req_ren[0] = 1'b1;
    bus.ramstate = S_BUSY;
    step();
    @(negedge clk);
    chk("wd_ren_before", 32'(bus.ramREN), 1);
    step();
    bus.req_ren[0] = 1'b0;
    @(negedge clk);
    chk("wd_ren", 32'(bus.ramREN), 0);
    chk("wd_wen", 32'(bus.ramWEN), 0);
    chk("wd_wait", 32'(bus.req_wait), 32'b1111);
    step();
    @(negedge clk);
    chk("wd_idle_busy", 32'(bus.busy), 0);
    chk("wd_err", 32'(bus.err), 0);

    // Burst at the top of the address space wraps to zero.
    step();
    bus.req_addr[2] = 32'hFFFFFFFC;
    bus.req_ren[2] = 1'b1;
    bus.req_burst[2] = 1'b1;
    bus.ramstate = S_ACC;
    step();
    @(negedge clk);
    chk("wrap_grant", 32'(bus.grant_id), 2);
    chk("wrap_addr0", bus.ramaddr, 32'hFFFFFFFC);
    step();
    @(negedge clk);
    chk("wrap_addr1", bus.ramaddr, 32'h0);
    chk("wrap_wait1", 32'(bus.req_wait), 32'b1011);
    step();
    bus.req_ren[2] = 1'b0;
    bus.req_burst[2] = 1'b0;

    // Reset asserted in XFER1.
    step();
    bus.req_addr[1] = 32'h300;
    bus.req_ren[1] = 1'b1;
    bus.req_burst[1] = 1'b1;
    bus.ramstate = S_ACC;
    step();
    step();
    bus.ramstate = S_BUSY;
    @(negedge clk);
    chk("rx_busy", 32'(bus.busy), 1);
    chk("rx_addr", bus.ramaddr, 32'h304);
    #1;
    nrst = 1'b0;
    #1;
    chk_reset("rst_xfer1");
    step();
    bus.req_ren[1] = 1'b0;
    bus.req_burst[1] = 1'b0;
    nrst = 1'b1;

    // Priority and fairness with all four requesters pending.
    step();
    bus.ramstate = S_ACC;
    bus.req_ren = '1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      if (bus.req_wait != '1) got.push_back(int'(bus.grant_id));
      step();
    end
    bus.req_ren[1:0] = 2'b00;
    chk("prio_d_count", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("prio_d%0d", i), 32'(got[i]), 32'(exp_d[i]));
    got.delete();
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      @(negedge clk);
      if (bus.req_wait != '1) got.push_back(int'(bus.grant_id));
      step();
    end
    bus.req_ren = '0;
    chk("prio_i_count", 32'(got.size()), 3);
    for (int i = 0; i < got.size(); i++) chk($sformatf("prio_i%0d", i), 32'(got[i]), 32'(exp_i[i]));

    // Randomized traffic; each requester owns a private 64-word region.
    step();
    for (int r = 0; r < N; r++) begin
      act[r] = 1'b0;
      left[r] = 0;
      w2data[r] = '0;
    end
    issued = 0;
    rand_phase = 1'b1;
    for (int c = 0; c < 20000 && (issued < TXNS || any_act(act)); c++) begin
      @(negedge clk);
      done = ~bus.req_wait;
      if (bus.ramWEN && bus.ramstate == S_ACC) ram_mem[bus.ramaddr[9:2]] = bus.ramstore;
      step();
      for (int r = 0; r < N; r++) begin
        if (act[r] && done[r]) begin
          left[r]--;
          if (left[r] > 0) begin
            bus.req_store[r] = w2data[r];
          end else begin
            bus.req_ren[r] = 1'b0;
            bus.req_wen[r] = 1'b0;
            bus.req_burst[r] = 1'b0;
            act[r] = 1'b0;
          end
        end else if (!act[r] && issued < TXNS && $urandom_range(0, 2) == 0) begin
          int          w;
          bit          br, wr;
          logic [31:0] d1;
          br = 1'($urandom_range(0, 1));
          wr = 1'($urandom_range(0, 1));
          w  = r * 64 + int'($urandom_range(0, 62));
          d1 = $urandom;
          w2data[r] = $urandom;
          bus.req_addr[r]  = 32'(w * 4);
          bus.req_burst[r] = br;
          bus.req_wen[r]   = wr;
          bus.req_ren[r]   = !wr || ($urandom_range(0, 3) == 0);
          bus.req_store[r] = d1;
          for (int k = 0; k <= int'(br); k++) begin
            if (wr) begin
              exp_mem[w + k] = (k == 0) ? d1 : w2data[r];
              exp_q[r].push_back('{addr: 32'((w + k) * 4), wr: 1'b1, data: exp_mem[w + k]});
            end else begin
              exp_q[r].push_back('{addr: 32'((w + k) * 4), wr: 1'b0, data: exp_mem[w + k]});
            end
          end
          left[r] = int'(br) + 1;
          act[r]  = 1'b1;
          issued++;
        end
      end
      bus.ramstate = ($urandom_range(0, 2) != 0) ? S_ACC : 2'($urandom_range(0, 1));
    end
    @(negedge clk);
    rand_phase = 1'b0;
    chk("rand_all_done", 32'(any_act(act)), 0);
    for (int r = 0; r < N; r++) chk($sformatf("rand_q%0d_empty", r), 32'(exp_q[r].size()), 0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem_%0d", i), ram_mem[i], exp_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single RAM port between all cache requesters of a multicore build.
- Requesters are the data caches and the instruction caches.
- Sequences one- or two-word transfers against the RAM `ramstate` handshake.
- Priority is data over instruction, round-robin within each class.
- Sits between the cache front-ends and the RAM model, below the coherence controller.

## Interface
Parameters:
- CPUS, 2, number of cores. N = 2*CPUS requesters.
  - Index 0..CPUS-1 are data caches.
  - Index CPUS..N-1 are instruction caches.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req_ren  in  N  read request per requester
- req_wen  in  N  write request per requester
- req_burst  in  N  1 = two-word block transfer, 0 = single word
- req_addr  in  N x WORD_W  byte address; held stable for the whole transfer
- req_store  in  N x WORD_W  write data; the requester updates it for the second word after the first word's wait-low cycle
- req_wait  out  N  0 for exactly the cycle a word completes for that requester
- req_load  out  WORD_W  ramload forwarded; valid while the granted requester's req_wait is 0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- grant_id  out  $clog2(N)  index of the current owner
- busy  out  1  transfer in progress
- err  out  1  one-cycle pulse on RAM ERROR

## Operation
- A requester is pending when req_ren|req_wen is 1. If both are 1, the request is a write.
- Pointers:
  - rr_d is the round-robin pointer over the data requesters.
  - rr_i is the round-robin pointer over the instruction requesters.
  - Both reset to their class base (0 and CPUS).
- Selection, evaluated in IDLE only:
  - If any data requester is pending, grant the first pending one at or after rr_d, wrapping within the data class.
  - Otherwise grant the first pending instruction requester at or after rr_i, wrapping within the instruction class.
  - On grant, set the class pointer to granted+1, wrapping to the class base.
- States:
  - IDLE: ram* outputs 0, busy=0. If any requester is pending, latch grant g and burst flag b, then go to XFER0. Otherwise stay.
  - XFER0: drive ramaddr=req_addr[g] and ramstore=req_store[g]. ramWEN=req_wen[g]; ramREN=req_ren[g]&~req_wen[g].
    - On ACCESS: req_wait[g]=0. Go to XFER1 if b, else IDLE.
    - On ERROR: err=1, req_wait[g]=0, go to IDLE.
    - On FREE/BUSY: hold.
  - XFER1: same drive as XFER0 but ramaddr=req_addr[g]+4, with modulo 2^WORD_W wrap. On ACCESS or ERROR, go to IDLE, with the same outputs as XFER0.
- Withdrawal: if req_ren[g] and req_wen[g] are both 0 in XFER0/XFER1, drop ram enables that cycle and return to IDLE. There is no wait-low pulse and no err.
- The grant is never preempted mid-transfer, regardless of higher-priority arrivals.
- Non-granted requesters see req_wait=1 at all times.
- grant_id holds the last granted index in IDLE.

## Timing
- Reset values:
  - state=IDLE
  - req_wait all 1
  - req_load, ramaddr, ramstore = 0
  - ramREN, ramWEN = 0
  - grant_id=0, busy=0, err=0
  - rr_d=0, rr_i=CPUS
- The grant is registered. A request first seen in cycle t drives the RAM in cycle t+1.
- With ACCESS returned immediately:
  - Single-word: req_wait=0 in t+1.
  - Burst: req_wait=0 in t+1 and t+2.
- After a completed transfer there is one IDLE cycle before the next grant. Back-to-back throughput is 1 word per 2 cycles single, 2 words per 3 cycles burst.
- busy=1 in XFER0/XFER1 only. err is combinational in the ERROR cycle.
- Reset asserted mid-transfer forces all outputs to reset values immediately. Any partial burst is abandoned.

## Test plan
- Single read, d0: req_ren[0]=1, addr 0x100, ramstate=ACCESS with ramload 0xDEADBEEF → ramREN=1 and ramaddr=0x100 in cycle 1; req_wait[0]=0 with req_load=0xDEADBEEF in that cycle; IDLE next.
- Burst write, d1, addr 0x200, ramstate BUSY 2 cycles then ACCESS, per word → ramaddr=0x200 then 0x204; req_wait[1] low exactly twice; ramWEN=1 throughout.
- Priority and fairness: i0, i1, d0 and d1 all pending continuously, single-word, immediate ACCESS → grant order 0,1,0,1 while data is pending; after data drops, grant order 2,3,2.
- Read+write simultaneous on d0 → ramWEN=1, ramREN=0.
- ERROR on first word of a burst → err pulses one cycle; req_wait[g]=0; no second word; state returns to IDLE.
- Withdrawal and reset: drop req_ren[g] while in XFER0 under BUSY → ram enables 0 that cycle, IDLE next, no wait pulse. Assert nRST=0 during XFER1 → all outputs at reset values in the same cycle.
